// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle datapath (fetch, decode, execute, memory, writeback).
// Outputs decode from the registered state plus op; a low reset forces every output to 0 at once.
module multicycle_controller #(
    parameter logic [3:0] ALUOP_ADD = 4'b0000,
    parameter logic [3:0] ALUOP_SUB = 4'b0001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       IRwrite,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCwrite,
    output logic       PCwritecond,
    output logic       RegDst,
    output logic       branch,
    output logic       regA_mux,
    output logic [3:0] ALUop,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCsource,
    output logic [1:0] Load,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        R_EXEC   = 4'd2,
        I_EXEC   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t st, nxt;

    always_ff @(posedge clock or negedge reset)
        if (!reset) st <= FETCH;
        else        st <= nxt;

    assign state = st;

    // Decoding is gated by reset so FETCH's strobes cannot leak out while reset is held low.
    always_comb begin
        nxt         = FETCH;
        IRwrite     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        PCwrite     = 1'b0;
        PCwritecond = 1'b0;
        RegDst      = 1'b0;
        branch      = 1'b0;
        regA_mux    = 1'b0;
        ALUop       = 4'd0;
        ALUsrcA     = 2'd0;
        ALUsrcB     = 2'd0;
        PCsource    = 2'd0;
        Load        = 2'd0;
        halted      = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            case (st)
                FETCH: begin
                    IRwrite = 1'b1;
                    PCwrite = 1'b1;
                    ALUsrcB = 2'd1;
                    ALUop   = ALUOP_ADD;
                    nxt     = DECODE;
                end
                DECODE: begin
                    ALUsrcB  = 2'd2;
                    ALUop    = ALUOP_ADD;
                    regA_mux = op[5:4] == 2'b00;
                    casez (op)
                        6'b00????: nxt = R_EXEC;
                        6'b01????: nxt = I_EXEC;
                        6'b100000: nxt = MEM_ADDR;
                        6'b100001: nxt = MEM_WR;
                        6'b11000?: nxt = BRANCH;
                        6'b111000: nxt = JUMP;
                        6'b111111: nxt = HALT;
                        default:   illegal = 1'b1;
                    endcase
                end
                R_EXEC: begin
                    regA_mux = 1'b1;
                    ALUsrcA  = 2'd1;
                    ALUop    = op[3:0];
                    nxt      = ALU_WB;
                end
                I_EXEC: begin
                    ALUsrcA = 2'd1;
                    ALUsrcB = 2'd2;
                    ALUop   = op[3:0];
                    nxt     = ALU_WB;
                end
                ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = op[5:4] == 2'b00;
                end
                MEM_ADDR, MEM_RD, MEM_WB: begin
                    ALUsrcA  = 2'd1;
                    ALUsrcB  = 2'd2;
                    ALUop    = ALUOP_ADD;
                    Load     = st == MEM_ADDR ? 2'd0 : 2'd1;
                    MemtoReg = st == MEM_WB;
                    RegWrite = st == MEM_WB;
                    nxt      = st == MEM_ADDR ? MEM_RD : st == MEM_RD ? MEM_WB : FETCH;
                end
                MEM_WR: MemWrite = 1'b1;
                BRANCH: begin
                    ALUsrcA     = 2'd1;
                    ALUop       = ALUOP_SUB;
                    PCwritecond = 1'b1;
                    PCsource    = 2'd1;
                    branch      = ~op[0];
                end
                JUMP: begin
                    PCwrite  = 1'b1;
                    PCsource = 2'd2;
                end
                HALT: begin
                    halted = 1'b1;
                    nxt    = HALT;
                end
                default: nxt = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; each instruction pushes its expected per-cycle outputs, popped and compared every cycle.
module tb_multicycle_controller;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [8:0] IRW = 9'h100, MW = 9'h080, MTR = 9'h040, RW = 9'h020, PCW = 9'h010;
    localparam logic [8:0] PCWC = 9'h008, RD = 9'h004, BR = 9'h002, RAM = 9'h001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst, branch, regA_mux;
    logic [3:0] ALUop, state;
    logic [1:0] ALUsrcA, ALUsrcB, PCsource, Load;
    logic halted, illegal;

    typedef struct packed {
        logic [3:0] st;
        logic [8:0] s;
        logic [3:0] alu;
        logic [1:0] a, b, pcs, ld;
        logic       h, il;
    } exp_t;

    exp_t obs;
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cycles = 0;

    multicycle_controller #(.ALUOP_ADD(ADD), .ALUOP_SUB(SUB)) dut (
        .clock(clock), .reset(reset), .op(op),
        .IRwrite(IRwrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .PCwrite(PCwrite), .PCwritecond(PCwritecond), .RegDst(RegDst), .branch(branch),
        .regA_mux(regA_mux), .ALUop(ALUop), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .PCsource(PCsource), .Load(Load), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs = {state, IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst,
                  branch, regA_mux, ALUop, ALUsrcA, ALUsrcB, PCsource, Load, halted, illegal};

    function automatic exp_t mk(input logic [3:0] st, input logic [8:0] s, input logic [3:0] alu,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] pcs,
                                input logic [1:0] ld, input logic h, input logic il);
        return {st, s, alu, a, b, pcs, ld, h, il};
    endfunction

    task automatic push_instr(input logic [5:0] o);
        logic legal;
        legal = o[5] == 1'b0 || o == 6'b100000 || o == 6'b100001 || o == 6'b110000 ||
                o == 6'b110001 || o == 6'b111000 || o == 6'b111111;
        q.push_back(mk(4'd0, IRW | PCW, ADD, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
        q.push_back(mk(4'd1, o[5:4] == 2'b00 ? RAM : 9'h0, ADD, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, ~legal));
        if (o[5:4] == 2'b00) begin
            q.push_back(mk(4'd2, RAM, o[3:0], 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
            q.push_back(mk(4'd4, RW | RD, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        end else if (o[5:4] == 2'b01) begin
            q.push_back(mk(4'd3, 9'h0, o[3:0], 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0));
            q.push_back(mk(4'd4, RW, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        end else if (o == 6'b100000) begin
            q.push_back(mk(4'd5, 9'h0, ADD, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0));
            q.push_back(mk(4'd6, 9'h0, ADD, 2'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0));
            q.push_back(mk(4'd7, MTR | RW, ADD, 2'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0));
        end else if (o == 6'b100001) begin
            q.push_back(mk(4'd8, MW, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        end else if (o == 6'b110000 || o == 6'b110001) begin
            q.push_back(mk(4'd9, PCWC | (o[0] ? 9'h0 : BR), SUB, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0));
        end else if (o == 6'b111000) begin
            q.push_back(mk(4'd10, PCW, 4'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0));
        end else if (o == 6'b111111) begin
            repeat (20) q.push_back(mk(4'd11, 9'h0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0));
        end
    endtask

    task automatic check(input string tag, input exp_t x);
        n_chk++;
        assert (obs === x) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, x);
        end
    endtask

    task automatic invariants();
        n_chk++;
        assert ((PCwrite & PCwritecond) === 1'b0) else begin
            n_fail++;
            $error("FAIL pcw_excl observed=%b%b expected=not both", PCwrite, PCwritecond);
        end
        n_chk++;
        assert ((MemWrite & RegWrite) === 1'b0) else begin
            n_fail++;
            $error("FAIL mem_reg_excl observed=%b%b expected=not both", MemWrite, RegWrite);
        end
        n_chk++;
        assert ((state <= 4'd11) === 1'b1) else begin
            n_fail++;
            $error("FAIL state_range observed=%0d expected=<=11", state);
        end
    endtask

    // Called just after a falling edge; each step compares the current cycle then advances one cycle.
    task automatic drain(input int n);
        exp_t x;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            #1;
            x = q.pop_front();
            check($sformatf("op%b_st%0d", op, x.st), x);
            invariants();
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic run(input logic [5:0] o);
        op = o;
        push_instr(o);
        drain(64);
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b0;
        #1 check(tag, mk(4'd0, 9'h0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        q.delete();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #2 check("in_reset", mk(4'd0, 9'h0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b1;
        run(6'b000000);
        run(6'b010011);
        run(6'b100000);
        run(6'b100001);
        run(6'b110001);
        run(6'b110000);
        run(6'b111000);
        run(6'b101010);
        run(6'b001111);
        op = 6'b100000;
        push_instr(op);
        drain(4);
        async_reset("reset_mid_lw");
        run(6'b011010);
        run(6'b111111);
        async_reset("reset_in_halt");
        run(6'b000101);
        while (cycles < 10000) begin
            logic [5:0] o;
            o = 6'($urandom_range(0, 62));
            run(o);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_ADD, default 4'b0000, ALUop code the ALU decodes as add.
REQ-002 Parameter ALUOP_SUB, default 4'b0001, ALUop code the ALU decodes as subtract.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op  input  6  opcode field from the instruction register; stable from the end of FETCH until the next FETCH.
REQ-006 IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst, branch, regA_mux  output  1 each  datapath control strobes/selects.
REQ-007 ALUop  output  4  ALU function.
REQ-008 ALUsrcA, ALUsrcB, PCsource, Load  output  2 each  mux selects:
- ALUsrcA: 0=PC, 1=regA, 2=imm.
- ALUsrcB: 0=regB, 1=const 1, 2=sign-ext imm, 3=zero-ext imm.
- PCsource: 0=ALU result, 1=ALU register, 2=jump.
- Load: 0=imm, 1=ALU register, 2=ALU result.
REQ-009 state  output  4  current state code, for debug.
REQ-010 halted  output  1  high while in HALT.
REQ-011 illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode.

Function
REQ-012 Moore FSM; outputs SHALL decode from the registered state plus op only, with every control output 0 unless listed for the state.
REQ-013 State codes SHALL be:
- FETCH=0, DECODE=1, R_EXEC=2, I_EXEC=3, ALU_WB=4, MEM_ADDR=5
- MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, HALT=11
- Codes 12-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH: IRwrite=1, PCwrite=1, ALUsrcA=0, ALUsrcB=1, ALUop=ALUOP_ADD, PCsource=0; next DECODE.
REQ-015 DECODE: ALUsrcA=0, ALUsrcB=2, ALUop=ALUOP_ADD (branch target into ALU register); regA_mux=1 when op[5:4]=00.
REQ-016 DECODE next-state map:
- 00xxxx -> R_EXEC; 01xxxx -> I_EXEC.
- 100000 (LW) -> MEM_ADDR; 100001 (SW) -> MEM_WR.
- 110000 (BEQ), 110001 (BNE) -> BRANCH; 111000 (JMP) -> JUMP; 111111 -> HALT.
- Any other op -> illegal=1, next FETCH (executes as NOP).
REQ-017 R_EXEC: regA_mux=1, ALUsrcA=1, ALUsrcB=0, ALUop=op[3:0]; next ALU_WB.
REQ-018 I_EXEC: ALUsrcA=1, ALUsrcB=2, ALUop=op[3:0]; next ALU_WB.
REQ-019 ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 if op[5:4]=00 else 0; next FETCH.
REQ-020 MEM_ADDR: ALUsrcA=1, ALUsrcB=2, ALUop=ALUOP_ADD; next MEM_RD.
REQ-021 MEM_RD: Load=1, ALU selects held as in MEM_ADDR; next MEM_WB.
REQ-022 MEM_WB: Load=1, MemtoReg=1, RegWrite=1, ALU selects as MEM_ADDR; next FETCH.
REQ-023 MEM_WR (SW, absolute address imm): Load=0, MemWrite=1 for exactly one cycle; next FETCH.
REQ-024 BRANCH: ALUsrcA=1, ALUsrcB=0, ALUop=ALUOP_SUB, PCwritecond=1, PCsource=1, branch=1 for BEQ / 0 for BNE; next FETCH.
REQ-025 JUMP: PCwrite=1, PCsource=2; next FETCH.
REQ-026 HALT: halted=1, all strobes 0; remains in HALT until reset.
REQ-027 Cycle counts SHALL be: R/I 4, LW 5, SW 3, BEQ/BNE 3, JMP 3, illegal 2.
REQ-028 PCwrite and PCwritecond SHALL never be high in the same cycle.
REQ-029 MemWrite and RegWrite SHALL never be high in the same cycle.

Reset
REQ-030 reset low SHALL force state=FETCH, halted=0, illegal=0 and all control outputs to 0 immediately, independent of clock.
REQ-031 The first rising edge after reset goes high SHALL be a FETCH cycle; reset mid-instruction SHALL abandon it with no further writes.

Verification
REQ-032 Reset, then op=000000 -> state sequence 0,1,2,4,0; RegWrite=1 and RegDst=1 only in ALU_WB.
REQ-033 op=100000 -> sequence 0,1,5,6,7,0; Load=1 in states 6 and 7; MemtoReg=1 and RegWrite=1 only in 7.
REQ-034 op=110001 -> BRANCH with PCwritecond=1, branch=0, PCsource=1, ALUop=ALUOP_SUB; op=110000 -> branch=1.
REQ-035 op=101010 -> illegal=1 for one cycle in DECODE; next state FETCH; no write strobe asserted.
REQ-036 op=111111 -> halted=1 held for 20 cycles; reset pulse low mid-cycle -> outputs 0 asynchronously, then FETCH.
REQ-037 Random legal/illegal op stream over 10k cycles -> assertions REQ-028 and REQ-029 never fire; state never leaves codes 0-11.
